// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: grant states, requester IDs,
// and the SDRAM base address.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_G0   = 2'd1,
        ARB_G1   = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    localparam logic [31:0] SDRAM_BASE = 32'h0000_0000;

    function automatic arb_state_t grant_of(input req_id_t id);
        return id ? ARB_G1 : ARB_G0;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM style bus bundle with active-low read_n/write_n commands.
// The arbiter takes the slave view on each requester and the master view on the SDRAM side.
interface sdram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 16
);
    logic                  read_n;
    logic                  write_n;
    logic                  chipselect;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W/8-1:0]   byteenable;
    logic                  waitrequest;
    logic                  readdatavalid;
    logic [DATA_W-1:0]     readdata;

    modport master (
        output read_n, write_n, chipselect, address, writedata, byteenable,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  read_n, write_n, address, writedata, byteenable,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// In-order read tag FIFO: one requester ID per outstanding read.
// A pop frees a slot for a push in the same cycle even when full.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  req_id_t                  push_id,
    input  logic                     pop,
    output req_id_t                  head_id,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    req_id_t          mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of one SDRAM Avalon-MM slave, with in-order read tagging.
// Define SDRAM_ARB_STATS_EN to add the stat_acc0/stat_acc1/stat_gate counters.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_OUT  = 8,
    parameter int unsigned HOLD_MAX = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    sdram_port_arbiter_if.slave          m0,
    sdram_port_arbiter_if.slave          m1,
    sdram_port_arbiter_if.master         sdram,
    output logic                         err
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [31:0]                  stat_acc0,
    output logic [31:0]                  stat_acc1,
    output logic [31:0]                  stat_gate
`endif
);
    localparam int unsigned HW = $clog2(HOLD_MAX + 1);
    localparam int unsigned CW = $clog2(MAX_OUT) + 1;

    arb_state_t state, state_nx;
    req_id_t    last_grant, last_grant_nx;
    logic [HW-1:0] hold_cnt, hold_nx;

    logic    req0, req1, g_req, other_req, g_wr, g_rd;
    logic    granted, gate, accept, hold_hit;
    req_id_t gid;

    logic [ADDR_W-1:0]   g_address;
    logic [DATA_W-1:0]   g_writedata;
    logic [DATA_W/8-1:0] g_byteenable;

    req_id_t         tag_head;
    logic [CW-1:0]   tag_count;
    logic            tag_full, tag_empty, tag_push, tag_pop;

    assign req0 = ~m0.read_n | ~m0.write_n;
    assign req1 = ~m1.read_n | ~m1.write_n;

    assign granted   = (state != ARB_IDLE);
    assign gid       = (state == ARB_G1);
    assign g_req     = gid ? req1 : req0;
    assign other_req = gid ? req0 : req1;
    // Write wins if a requester illegally asserts both commands.
    assign g_wr      = gid ? ~m1.write_n : ~m0.write_n;
    assign g_rd      = ~g_wr & (gid ? ~m1.read_n : ~m0.read_n);

    assign g_address    = gid ? m1.address    : m0.address;
    assign g_writedata  = gid ? m1.writedata  : m0.writedata;
    assign g_byteenable = gid ? m1.byteenable : m0.byteenable;

    assign gate     = granted & g_rd & (tag_count == CW'(MAX_OUT));
    assign accept   = granted & g_req & ~gate & ~sdram.waitrequest;
    assign hold_hit = accept & (hold_cnt == HW'(HOLD_MAX - 1));

    assign tag_push = accept & g_rd & ~tag_full;
    assign tag_pop  = sdram.readdatavalid & ~tag_empty;

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (tag_push),
        .push_id (gid),
        .pop     (tag_pop),
        .head_id (tag_head),
        .count   (tag_count),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    assign sdram.chipselect = 1'b1;

    always_comb begin
        sdram.read_n     = 1'b1;
        sdram.write_n    = 1'b1;
        sdram.address    = '0;
        sdram.byteenable = '1;
        sdram.writedata  = '0;
        m0.waitrequest   = 1'b1;
        m1.waitrequest   = 1'b1;
        if (granted) begin
            sdram.read_n     = ~(g_rd & ~gate);
            sdram.write_n    = ~g_wr;
            sdram.address    = g_address;
            sdram.byteenable = g_byteenable;
            sdram.writedata  = g_writedata;
            if (gid) m1.waitrequest = sdram.waitrequest | gate;
            else     m0.waitrequest = sdram.waitrequest | gate;
        end
    end

    assign m0.readdatavalid = tag_pop & (tag_head == 1'b0);
    assign m1.readdatavalid = tag_pop & (tag_head == 1'b1);
    assign m0.readdata      = sdram.readdata;
    assign m1.readdata      = sdram.readdata;

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        hold_nx       = hold_cnt;
        case (state)
            ARB_IDLE: begin
                if (req0 | req1) begin
                    // On a tie the requester that did not hold the last grant wins.
                    last_grant_nx = (req0 & req1) ? ~last_grant : req1;
                    state_nx      = grant_of(last_grant_nx);
                    hold_nx       = '0;
                end
            end
            ARB_G0, ARB_G1: begin
                if (~g_req | hold_hit) begin
                    hold_nx = '0;
                    if (other_req) begin
                        state_nx      = grant_of(~gid);
                        last_grant_nx = ~gid;
                    end else if (!hold_hit) begin
                        state_nx = ARB_IDLE;
                    end
                end else if (accept) begin
                    hold_nx = hold_cnt + HW'(1);
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
            hold_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            hold_cnt   <= hold_nx;
            if (sdram.readdatavalid & tag_empty) err <= 1'b1;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_acc0 <= '0;
            stat_acc1 <= '0;
            stat_gate <= '0;
        end else begin
            if (accept & ~gid) stat_acc0 <= stat_acc0 + 32'd1;
            if (accept &  gid) stat_acc1 <= stat_acc1 + 32'd1;
            if (gate)          stat_gate <= stat_gate + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: requester drivers, an SDRAM memory model,
// and a monitor that routes every returned beat against an in-order expectation queue.
module tb_sdram_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned MO = 8;
    localparam int unsigned HM = 4;

    logic clk = 1'b0;
    logic reset;
    logic err;
    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sd_if ();

`ifdef SDRAM_ARB_STATS_EN
    logic [31:0] stat_acc0, stat_acc1, stat_gate;
`endif

    sdram_port_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_OUT  (MO),
        .HOLD_MAX (HM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .sdram (sd_if),
        .err   (err)
`ifdef SDRAM_ARB_STATS_EN
        ,
        .stat_acc0 (stat_acc0),
        .stat_acc1 (stat_acc1),
        .stat_gate (stat_gate)
`endif
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    be;
    } cmd_t;
    typedef struct { int own; logic [DW-1:0] data; } exp_t;
    typedef struct { int unsigned due; logic [DW-1:0] data; } rsp_t;

    int n_vec = 0;
    int n_err = 0;
    int unsigned cyc = 0;
    cmd_t q0[$], q1[$];
    exp_t expq[$];
    rsp_t rspq[$];
    int acc_log[$];
    int unsigned acc_cnt[2], acc_cyc[2], beats[2];
    int unsigned last_due = 0;
    bit rand_gap = 0, rand_wait = 0, rand_lat = 0, rsp_hold = 0;
    int rsp_credit = 0;
    logic [DW-1:0] ref_mem[16], sd_mem[16];
    bit pres[2], acc[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [1:0] be);
        logic [DW-1:0] r = old;
        if (be[0]) r[7:0]  = nw[7:0];
        if (be[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    function automatic cmd_t rnd_cmd(input bit force_read);
        cmd_t c;
        c.wr   = force_read ? 1'b0 : 1'($urandom_range(0, 1));
        c.addr = AW'($urandom_range(0, 15));
        c.data = DW'($urandom);
        c.be   = 2'($urandom_range(1, 3));
        return c;
    endfunction

    task automatic drive(input int i, input bit on, input cmd_t c);
        logic rn = on ? c.wr : 1'b1;
        logic wn = on ? ~c.wr : 1'b1;
        if (i == 0) begin
            m0_if.read_n = rn; m0_if.write_n = wn; m0_if.address = c.addr;
            m0_if.writedata = c.data; m0_if.byteenable = c.be;
        end else begin
            m1_if.read_n = rn; m1_if.write_n = wn; m1_if.address = c.addr;
            m1_if.writedata = c.data; m1_if.byteenable = c.be;
        end
    endtask

    // Requester drivers: hold a command until accepted, then optionally idle a cycle.
    initial begin : req_drv
        cmd_t c;
        m0_if.chipselect = 1'b1;
        m1_if.chipselect = 1'b1;
        c = rnd_cmd(1'b0);
        drive(0, 1'b0, c);
        drive(1, 1'b0, c);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                acc[i] = pres[i] && !reset &&
                         !((i == 0) ? m0_if.waitrequest : m1_if.waitrequest);
                if (acc[i]) begin
                    c = (i == 0) ? q0[0] : q1[0];
                    acc_cnt[i]++;
                    acc_cyc[i] = cyc;
                    acc_log.push_back(i);
                    if (c.wr) ref_mem[c.addr[3:0]] = merge(ref_mem[c.addr[3:0]], c.data, c.be);
                    else      expq.push_back('{own: i, data: ref_mem[c.addr[3:0]]});
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    if (i == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                    pres[i] = 1'b0;
                end
                if (!pres[i]) begin
                    if (((i == 0) ? q0.size() : q1.size()) > 0 &&
                        !(rand_gap && $urandom_range(0, 3) == 0)) begin
                        c = (i == 0) ? q0[0] : q1[0];
                        drive(i, 1'b1, c);
                        pres[i] = 1'b1;
                    end else begin
                        c = rnd_cmd(1'b0);
                        drive(i, 1'b0, c);
                    end
                end
            end
        end
    end

    // SDRAM slave model: memory, random stalls, in-order responses after a latency.
    initial begin : sdram_model
        rsp_t r;
        sd_if.waitrequest   = 1'b0;
        sd_if.readdatavalid = 1'b0;
        sd_if.readdata      = '0;
        forever begin
            @(negedge clk);
            if (!reset && !sd_if.waitrequest) begin
                if (!sd_if.write_n) begin
                    sd_mem[sd_if.address[3:0]] = merge(sd_mem[sd_if.address[3:0]],
                                                      sd_if.writedata, sd_if.byteenable);
                end else if (!sd_if.read_n) begin
                    r.due = cyc + (rand_lat ? $urandom_range(1, 4) : 2);
                    if (r.due <= last_due) r.due = last_due + 1;
                    last_due = r.due;
                    r.data = sd_mem[sd_if.address[3:0]];
                    rspq.push_back(r);
                end
            end
            @(posedge clk);
            #1;
            if (rspq.size() > 0 && rspq[0].due <= cyc && (!rsp_hold || rsp_credit > 0)) begin
                if (rsp_hold) rsp_credit--;
                r = rspq.pop_front();
                sd_if.readdatavalid = 1'b1;
                sd_if.readdata      = r.data;
            end else begin
                sd_if.readdatavalid = 1'b0;
                sd_if.readdata      = DW'($urandom);
            end
            sd_if.waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    // Monitor: every SDRAM beat must reach exactly the requester that issued the read.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sd_if.readdatavalid) begin
                if (expq.size() == 0) begin
                    chk("stray_beat_strobe", {m1_if.readdatavalid, m0_if.readdatavalid}, 2'b00);
                end else begin
                    e = expq.pop_front();
                    chk("beat_owner", {m1_if.readdatavalid, m0_if.readdatavalid},
                        (e.own == 1) ? 2'b10 : 2'b01);
                    chk("beat_data", (e.own == 1) ? m1_if.readdata : m0_if.readdata, e.data);
                    beats[e.own]++;
                end
            end else if (m0_if.readdatavalid || m1_if.readdatavalid) begin
                chk("spurious_strobe", {m1_if.readdatavalid, m0_if.readdatavalid}, 2'b00);
            end
        end
    end

    task automatic do_reset(input bit flush_rsp);
        @(posedge clk);
        #1;
        reset = 1'b1;
        expq.delete();
        if (flush_rsp) rspq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        acc_log.delete();
        for (int i = 0; i < 2; i++) begin
            acc_cnt[i] = 0; beats[i] = 0; acc_cyc[i] = 0;
        end
    endtask

    task automatic wait_acc(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (acc_cnt[0] + acc_cnt[1] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("accept_timeout", (k >= budget) ? 1 : 0, 0);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || expq.size() > 0 || rspq.size() > 0)
               && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("drain_timeout", (k >= budget) ? 1 : 0, 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r[2], cur, n, k;
        int exp_seq[$];
        int unsigned rd_cnt[2];
        cmd_t c;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = DW'(16'h5A00 + i * 16'h0111);
            sd_mem[i]  = ref_mem[i];
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_wait", m0_if.waitrequest, 1);
        chk("rst_m1_wait", m1_if.waitrequest, 1);
        chk("rst_m0_rdv", m0_if.readdatavalid, 0);
        chk("rst_m1_rdv", m1_if.readdatavalid, 0);
        chk("rst_read_n", sd_if.read_n, 1);
        chk("rst_write_n", sd_if.write_n, 1);
        chk("rst_address", sd_if.address, 0);
        chk("rst_byteenable", sd_if.byteenable, 2'b11);
        chk("rst_writedata", sd_if.writedata, 0);
        chk("rst_chipselect", sd_if.chipselect, 1);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single requester, forwarded one cycle after first presentation
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            c = rnd_cmd(1'b1); c.addr = AW'(a); q0.push_back(c);
        end
        @(negedge clk);
        chk("fwd_not_early", sd_if.read_n, 1);
        @(negedge clk);
        chk("fwd_first", {sd_if.read_n, sd_if.address}, {1'b0, 32'd0});
        drain(200);
        chk("single_beats_m0", beats[0], 4);
        chk("single_beats_m1", beats[1], 0);

        // Simultaneous first request after reset
        do_reset(1'b1);
        @(negedge clk);
        c = rnd_cmd(1'b1); c.addr = AW'(4); q0.push_back(c);
        c = rnd_cmd(1'b1); c.addr = AW'(5); q1.push_back(c);
        drain(200);
        chk("simul_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            chk("simul_first", acc_log[0], 0);
            chk("simul_second", acc_log[1], 1);
            chk("simul_switch_gap", acc_cyc[1] - acc_cyc[0], 2);
        end

        // Hold limit with both requesters streaming
        do_reset(1'b1);
        @(negedge clk);
        r[0] = 12; r[1] = 8;
        for (int i = 0; i < r[0]; i++) q0.push_back(rnd_cmd(1'b0));
        for (int i = 0; i < r[1]; i++) q1.push_back(rnd_cmd(1'b0));
        drain(500);
        cur = 0;
        while (r[0] + r[1] > 0) begin
            n = (r[1 - cur] > 0 && r[cur] > int'(HM)) ? int'(HM) : r[cur];
            for (int i = 0; i < n; i++) exp_seq.push_back(cur);
            r[cur] -= n;
            if (r[1 - cur] > 0) cur = 1 - cur;
        end
        chk("hold_count", acc_log.size(), exp_seq.size());
        k = (acc_log.size() < exp_seq.size()) ? acc_log.size() : exp_seq.size();
        for (int i = 0; i < k; i++) chk($sformatf("hold_seq[%0d]", i), acc_log[i], exp_seq[i]);

        // Interleaved returns: 3 reads from m0, then 2 from m1, beats released afterwards
        do_reset(1'b1);
        rsp_hold = 1'b1; rsp_credit = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) q0.push_back(rnd_cmd(1'b1));
        for (int i = 0; i < 2; i++) q1.push_back(rnd_cmd(1'b1));
        wait_acc(5, 100);
        rsp_hold = 1'b0;
        drain(200);
        chk("inter_beats_m0", beats[0], 3);
        chk("inter_beats_m1", beats[1], 2);

        // Tag FIFO full gates the ninth read until one beat returns
        do_reset(1'b1);
        rsp_hold = 1'b1; rsp_credit = 0;
        @(negedge clk);
        for (int a = 0; a < 9; a++) begin
            c = rnd_cmd(1'b1); c.addr = AW'(a); q0.push_back(c);
        end
        wait_acc(8, 100);
        repeat (4) @(negedge clk);
        chk("full_accepts", acc_cnt[0], 8);
        chk("full_m0_wait", m0_if.waitrequest, 1);
        chk("full_read_n", sd_if.read_n, 1);
        rsp_credit = 1;
        @(negedge clk);
        chk("full_still_gated", sd_if.read_n, 1);
        @(negedge clk);
        chk("full_release", {sd_if.read_n, sd_if.address}, {1'b0, 32'd8});
        rsp_hold = 1'b0;
        drain(200);
        chk("full_beats_m0", beats[0], 9);

        // Reset with two reads in flight
        do_reset(1'b1);
        rsp_hold = 1'b1; rsp_credit = 0;
        @(negedge clk);
        q0.push_back(rnd_cmd(1'b1));
        q0.push_back(rnd_cmd(1'b1));
        wait_acc(2, 100);
        do_reset(1'b0);
        @(negedge clk);
        chk("inflight_err_clear", err, 0);
        rsp_credit = 1;
        @(negedge clk);
        chk("inflight_no_strobe", {m1_if.readdatavalid, m0_if.readdatavalid}, 2'b00);
        @(negedge clk);
        chk("inflight_err_set", err, 1);
        repeat (3) @(negedge clk);
        chk("inflight_err_sticky", err, 1);
        do_reset(1'b1);
        rsp_hold = 1'b0;
        @(negedge clk);
        chk("err_cleared_by_reset", err, 0);

        // Randomized traffic: stalls, gaps, variable latency, mixed reads/writes
        do_reset(1'b1);
        rand_gap = 1'b1; rand_wait = 1'b1; rand_lat = 1'b1;
        rd_cnt[0] = 0; rd_cnt[1] = 0;
        @(negedge clk);
        for (int i = 0; i < 150; i++) begin
            c = rnd_cmd(1'b0); q0.push_back(c); if (!c.wr) rd_cnt[0]++;
            c = rnd_cmd(1'b0); q1.push_back(c); if (!c.wr) rd_cnt[1]++;
        end
        drain(5000);
        chk("rand_accepts", acc_cnt[0] + acc_cnt[1], 300);
        chk("rand_beats_m0", beats[0], rd_cnt[0]);
        chk("rand_beats_m1", beats[1], rd_cnt[1]);
        chk("rand_no_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
